// File: rtl/data_sync_pkg.sv
// Shared definitions for the multi-channel data synchroniser.
package data_sync_pkg;

    // Smallest legal configuration values.
    localparam int MIN_STAGES = 2;
    localparam int MIN_CH     = 1;

    // Per-channel holding state: no word waiting, or one word waiting.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/data_sync_bit.sv
// NUM_STAGES-deep single-bit synchroniser, plain flop chain with reset.
module data_sync_bit #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic synced
);

    logic [NUM_STAGES-1:0] stages;

    // Shift the asynchronous level through the chain, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[NUM_STAGES-2:0], level};
        end
    end

    assign synced = stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel data synchroniser with per-channel valid/ready hold and
// sticky overrun. Define DATA_SYNC_TOGGLE_EN for toggle-encoded enables
// (every transition delivers a word); default is rising-edge level mode.
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           sync_valid,
    input  logic [NUM_CH-1:0]           sync_ready,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        overrun_clr
);

    if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
        $error("data_sync_mc: NUM_STAGES must be at least %0d", MIN_STAGES);
    end
    if (NUM_CH < MIN_CH) begin : g_bad_ch
        $error("data_sync_mc: NUM_CH must be at least %0d", MIN_CH);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                 synced;
        logic                 en_prev;
        logic                 evt;
        logic                 pulse_q;
        logic                 ovr_q;
        logic                 set_ovr;
        logic [BUS_WIDTH-1:0] data_q;
        ch_state_t            state;
        ch_state_t            state_nxt;

        data_sync_bit #(.NUM_STAGES(NUM_STAGES)) u_sync (
            .clk    (CLK),
            .rst_n  (RST),
            .level  (bus_enable[c]),
            .synced (synced)
        );

`ifdef DATA_SYNC_TOGGLE_EN
        assign evt = synced ^ en_prev;
`else
        assign evt = synced & ~en_prev;
`endif

        // Next holding state and overrun-set decision for this channel.
        always_comb begin
            state_nxt = state;
            set_ovr   = 1'b0;
            case (state)
                EMPTY: begin
                    if (evt) state_nxt = FULL;
                end
                FULL: begin
                    if (evt && !sync_ready[c]) set_ovr = 1'b1;
                    else if (!evt && sync_ready[c]) state_nxt = EMPTY;
                end
                default: state_nxt = EMPTY;
            endcase
        end

        // Edge history, capture, pulse, state and sticky overrun registers.
        always_ff @(posedge CLK) begin
            if (!RST) begin
                en_prev <= 1'b0;
                pulse_q <= 1'b0;
                data_q  <= '0;
                state   <= EMPTY;
                ovr_q   <= 1'b0;
            end else begin
                en_prev <= synced;
                pulse_q <= evt;
                if (evt) data_q <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                state   <= state_nxt;
                if (set_ovr) ovr_q <= 1'b1;
                else if (overrun_clr) ovr_q <= 1'b0;
            end
        end

        assign sync_bus[c*BUS_WIDTH +: BUS_WIDTH] = data_q;
        assign enable_pulse[c] = pulse_q;
        assign sync_valid[c]   = (state == FULL);
        assign overrun[c]      = ovr_q;
    end

endmodule

// File: tb/tb_data_sync_mc.sv
// Scoreboard bench for data_sync_mc: expected words are queued per channel
// when stimulus is issued and popped by a monitor on each enable_pulse.
module tb_data_sync_mc;

    localparam int NS = 2;
    localparam int BW = 8;
    localparam int NC = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NC*BW-1:0] unsync_bus;
    logic [NC-1:0] bus_enable;
    logic [NC*BW-1:0] sync_bus;
    logic [NC-1:0] enable_pulse;
    logic [NC-1:0] sync_valid;
    logic [NC-1:0] sync_ready;
    logic [NC-1:0] overrun;
    logic          overrun_clr;

    logic [BW-1:0] expq [NC][$];
    int            pulse_cnt [NC];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 CLK = ~CLK;

    data_sync_mc #(
        .NUM_STAGES (NS),
        .BUS_WIDTH  (BW),
        .NUM_CH     (NC)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_bus     (sync_bus),
        .enable_pulse (enable_pulse),
        .sync_valid   (sync_valid),
        .sync_ready   (sync_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_word(input int c, input logic [BW-1:0] w);
        unsync_bus[c*BW +: BW] = w;
    endtask

    // Monitor: every pulse must match the oldest queued word for its channel.
    always @(posedge CLK) begin
        logic [BW-1:0] e;
        #1;
        for (int c = 0; c < NC; c++) begin
            if (enable_pulse[c] === 1'b1) begin
                pulse_cnt[c]++;
                if (expq[c].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse_ch%0d: got data %0h expected no pulse",
                             c, sync_bus[c*BW +: BW]);
                end else begin
                    e = expq[c].pop_front();
                    check($sformatf("data_ch%0d", c), {24'd0, sync_bus[c*BW +: BW]}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        int pend;
        for (int c = 0; c < NC; c++) pulse_cnt[c] = 0;
        RST         = 1'b0;
        unsync_bus  = $urandom();
        bus_enable  = 4'($urandom());
        sync_ready  = 4'($urandom());
        overrun_clr = 1'b0;

        // Reset with random inputs
        repeat (2) @(posedge CLK);
        #1;
        check("rst_sync_bus", sync_bus, 32'd0);
        check("rst_pulse", {28'd0, enable_pulse}, 32'd0);
        check("rst_valid", {28'd0, sync_valid}, 32'd0);
        check("rst_overrun", {28'd0, overrun}, 32'd0);
        @(negedge CLK);
        bus_enable = '0;
        sync_ready = '0;
        unsync_bus = '0;
        RST = 1'b1;
        repeat (6) @(posedge CLK);

        // Basic transfer on ch0
        @(negedge CLK);
        set_word(0, 8'hC1);
        bus_enable[0] = 1'b1;
        expq[0].push_back(8'hC1);
        repeat (3) @(posedge CLK);
        #1;
        check("basic_pulse", {31'd0, enable_pulse[0]}, 32'd1);
        check("basic_valid", {28'd0, sync_valid}, 32'h1);
        @(posedge CLK);
        #1;
        check("basic_pulse_one_cycle", {31'd0, enable_pulse[0]}, 32'd0);

        // Retain while enable stays high, then re-arm
        @(negedge CLK);
        set_word(0, 8'hC0);
        repeat (6) @(posedge CLK);
        #1;
        check("retain_bus", {24'd0, sync_bus[7:0]}, 32'hC1);
        @(negedge CLK);
        bus_enable[0] = 1'b0;
`ifdef DATA_SYNC_TOGGLE_EN
        expq[0].push_back(8'hC0);
`endif
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        bus_enable[0] = 1'b1;
        expq[0].push_back(8'hC0);
        repeat (6) @(posedge CLK);
        #1;
        check("rearm_bus", {24'd0, sync_bus[7:0]}, 32'hC0);
        check("rearm_overrun0", {31'd0, overrun[0]}, 32'd1);
        @(negedge CLK);
        sync_ready[0] = 1'b1;
        @(posedge CLK);
        #1;
        check("consume_valid0", {31'd0, sync_valid[0]}, 32'd0);
        @(negedge CLK);
        sync_ready[0] = 1'b0;

        // Overrun on ch1
        set_word(1, 8'h11);
        bus_enable[1] = 1'b1;
        expq[1].push_back(8'h11);
        repeat (6) @(posedge CLK);
        #1;
        check("ovr_first_valid", {31'd0, sync_valid[1]}, 32'd1);
        check("ovr_first_flag", {31'd0, overrun[1]}, 32'd0);
        @(negedge CLK);
        bus_enable[1] = 1'b0;
`ifdef DATA_SYNC_TOGGLE_EN
        expq[1].push_back(8'h11);
`endif
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        set_word(1, 8'h22);
        bus_enable[1] = 1'b1;
        expq[1].push_back(8'h22);
        repeat (6) @(posedge CLK);
        #1;
        check("ovr_bus", {24'd0, sync_bus[15:8]}, 32'h22);
        check("ovr_valid", {31'd0, sync_valid[1]}, 32'd1);
        check("ovr_flag", {31'd0, overrun[1]}, 32'd1);
        @(negedge CLK);
        overrun_clr = 1'b1;
        @(posedge CLK);
        #1;
        check("ovr_clr", {28'd0, overrun}, 32'd0);
        @(negedge CLK);
        overrun_clr = 1'b0;

        // Event coincident with ready on a FULL ch2
        set_word(2, 8'h33);
        bus_enable[2] = 1'b1;
        expq[2].push_back(8'h33);
        repeat (6) @(posedge CLK);
        #1;
        check("sim_pre_valid", {31'd0, sync_valid[2]}, 32'd1);
        @(negedge CLK);
`ifdef DATA_SYNC_TOGGLE_EN
        set_word(2, 8'h44);
        bus_enable[2] = 1'b0;
`else
        bus_enable[2] = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        set_word(2, 8'h44);
        bus_enable[2] = 1'b1;
`endif
        expq[2].push_back(8'h44);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        sync_ready[2] = 1'b1;
        @(posedge CLK);
        #1;
        check("sim_pulse", {31'd0, enable_pulse[2]}, 32'd1);
        check("sim_valid", {31'd0, sync_valid[2]}, 32'd1);
        check("sim_overrun", {31'd0, overrun[2]}, 32'd0);
        check("sim_bus", {24'd0, sync_bus[23:16]}, 32'h44);
        @(negedge CLK);
        sync_ready[2] = 1'b0;

        // Enable 0->1->0 on ch3
        set_word(3, 8'hA5);
        bus_enable[3] = 1'b1;
        expq[3].push_back(8'hA5);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        set_word(3, 8'h5A);
        bus_enable[3] = 1'b0;
`ifdef DATA_SYNC_TOGGLE_EN
        expq[3].push_back(8'h5A);
`endif
        repeat (6) @(posedge CLK);
        #1;
`ifdef DATA_SYNC_TOGGLE_EN
        check("tog_pulses", pulse_cnt[3], 32'd2);
        check("tog_bus", {24'd0, sync_bus[31:24]}, 32'h5A);
`else
        check("lvl_pulses", pulse_cnt[3], 32'd1);
        check("lvl_bus", {24'd0, sync_bus[31:24]}, 32'hA5);
`endif

        // Reset mid-operation with some enables held high
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rst_bus", sync_bus, 32'd0);
        check("mid_rst_valid", {28'd0, sync_valid}, 32'd0);
        check("mid_rst_overrun", {28'd0, overrun}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        expq[0].push_back(8'hC0);
        expq[1].push_back(8'h22);
`ifndef DATA_SYNC_TOGGLE_EN
        expq[2].push_back(8'h44);
`endif
        repeat (NS + 1) @(posedge CLK);
        #1;
`ifdef DATA_SYNC_TOGGLE_EN
        check("release_pulse", {28'd0, enable_pulse}, 32'h3);
        check("release_valid", {28'd0, sync_valid}, 32'h3);
`else
        check("release_pulse", {28'd0, enable_pulse}, 32'h7);
        check("release_valid", {28'd0, sync_valid}, 32'h7);
`endif
        check("release_overrun", {28'd0, overrun}, 32'd0);

        repeat (6) @(posedge CLK);
        #2;
        pend = 0;
        for (int c = 0; c < NC; c++) pend += expq[c].size();
        check("pending_words", pend, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sync_mc.md
# data_sync_mc

Multi-channel, parametrised successor to the single-bus data synchroniser. Each channel carries a bus and an enable qualifier from an asynchronous source domain. The enable passes through a NUM_STAGES flop chain, and the bus is captured on the detected enable event. Each channel then holds its word behind a valid/ready handshake with sticky overrun detection. The block sits at every clock-domain crossing into the destination (CLK) domain that moves multi-bit data on more than one channel.

## Interface
- NUM_STAGES, 2: synchroniser depth on each enable bit; legal range is 2 or more.
- BUS_WIDTH, 8: data width per channel.
- NUM_CH, 4: number of independent channels; legal range is 1 or more.

- CLK  in  1  destination-domain clock; everything is rising-edge.
- RST  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- unsync_bus  in  NUM_CH*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; the source holds it stable from before its enable event until the next event.
- bus_enable  in  NUM_CH  asynchronous per-channel qualifier.
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data, same packing as unsync_bus.
- enable_pulse  out  NUM_CH  one-cycle pulse, coincident with the sync_bus update.
- sync_valid  out  NUM_CH  channel holds an unconsumed word.
- sync_ready  in  NUM_CH  consumer accepts the word when sync_valid & sync_ready.
- overrun  out  NUM_CH  sticky flag: a word was overwritten before it was consumed.
- overrun_clr  in  1  clears every overrun bit.

## Operation
- Per-channel synchroniser: bus_enable[c] feeds flop stages s1..sN. en_prev is one further flop on sN. Edge event is sN & ~en_prev.
- On an event, the channel:
  - loads unsync_bus slice c into sync_bus slice c;
  - asserts enable_pulse[c] for exactly one cycle;
  - sets sync_valid[c].
- Without an event, sync_bus holds its value. Bus changes while enable stays high are ignored.
- Each channel's valid flag is a 2-state machine, EMPTY or FULL:
  - EMPTY -> FULL on an event.
  - FULL -> EMPTY on ready with no event.
  - FULL stays FULL on event+ready: new data loaded, no overrun.
  - FULL stays FULL on an event without ready: new data overwrites, overrun[c] is set.
- overrun[c] is set as above and cleared by overrun_clr. If set and clear happen in the same cycle, set wins.
- Channels are fully independent. There is no arbitration and no cross-channel ordering.

## Timing
- Reset values: sync_bus=0, enable_pulse=0, sync_valid=0, overrun=0. The s1..sN chains and en_prev are also 0.
- Latency: bus_enable first sampled high at edge k -> s1 at edge k, sN at edge k+N-1. Event registered at edge k+N, so sync_bus, enable_pulse and sync_valid update NUM_STAGES+1 edges after first sampling. Total uncertainty is +1 cycle for asynchronous arrival.
- Back-to-back: the minimum event spacing a source may rely on is one low and one high of at least NUM_STAGES+1 cycles each. Shorter excursions may be lost.
- Reset mid-operation clears all state in the same edge.
  - If bus_enable stays high through reset, one new event fires NUM_STAGES+1 edges after release.
  - A pending word is discarded without setting overrun.
- sync_ready with sync_valid=0 has no effect.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- DATA_SYNC_TOGGLE_EN defined: toggle-encoded enable. The event is sN ^ en_prev, so each transition of bus_enable (0->1 or 1->0) delivers one word. Reset-through-high in this mode produces one event on release.
- DATA_SYNC_TOGGLE_EN undefined: level mode. The event is rising edge only. Falling edges produce nothing.

## Structure
- Package data_sync_pkg holds:
  - localparam minimums MIN_STAGES=2 and MIN_CH=1, with elaboration-time checks against the parameters;
  - the channel state enum (EMPTY, FULL).
- One sub-module, data_sync_bit: NUM_STAGES-deep single-bit synchroniser with reset and no logic between stages. It is instantiated NUM_CH times through a generate loop.
- Capture, pulse, valid and overrun logic lives in the top module, per channel, inside the same generate loop.

## Test plan
- Reset: drive RST=0 for 2 cycles with random inputs -> all outputs 0. Release with bus_enable=0 -> no pulse.
- Basic transfer, NUM_STAGES=2:
  - Stimulus: ch0 bus=0xC1, bus_enable[0] rises at a negedge.
  - Response: after 3 clocks, sync_bus[0]=0xC1, enable_pulse[0] high exactly 1 cycle, sync_valid[0]=1. Other channels unchanged.
- Retain: with bus_enable[0] still high, change the bus to 0xC0 -> no pulse, sync_bus[0] stays 0xC1. Drop enable, then raise it again -> 0xC0 captured after 3 clocks.
- Overrun:
  - Stimulus: ch1 delivers 0x11 then 0x22 with sync_ready[1]=0.
  - Response: sync_bus[1]=0x22, sync_valid[1]=1, overrun[1]=1.
  - Pulsing overrun_clr -> overrun[1]=0.
- Simultaneous: an event on ch2 in the same cycle as sync_ready[2]=1 on a FULL channel -> new data loaded, sync_valid stays 1, overrun[2] stays 0.
- Toggle build, DATA_SYNC_TOGGLE_EN defined:
  - Stimulus: bus_enable[3] goes 0->1->0 with words 0xA5, 0x5A.
  - Response: two pulses, and sync_bus[3] ends at 0x5A. The same stimulus in a level-mode build gives one pulse.
